stack_alu_ext: RTL

STACK_ALU_EXT -- requirements
Module: stack_alu_ext

---
 rtl/stack_alu_ext_if.sv | 27 ++
 rtl/stack_alu_ext.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_alu_ext_if.sv
// Command/response bus for stack_alu_ext.
//   in_valid/opcode/input_data : command from master, accepted when in_ready
//   in_ready                   : slave can take a command
//   out_valid                  : one-cycle completion pulse
//   output_data/overflow/stack_err : result and status of the completing command
interface stack_alu_ext_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   opcode;
    logic [N-1:0] input_data;
    logic         out_valid;
    logic [N-1:0] output_data;
    logic         overflow;
    logic         stack_err;

    modport master (
        output in_valid, opcode, input_data,
        input  in_ready, out_valid, output_data, overflow, stack_err
    );

    modport slave (
        input  in_valid, opcode, input_data,
        output in_ready, out_valid, output_data, overflow, stack_err
    );
endinterface

// File: rtl/stack_alu_ext.sv
// Stack-based signed ALU with a sequential shift-add multiplier.
//   clk, rst    : clock, asynchronous active-high reset
//   bus (slave) : command/response handshake, see stack_alu_ext_if
//   full, empty : stack occupancy flags
//   depth       : current entry count
module stack_alu_ext #(
    parameter int N          = 16,
    parameter int STACK_SIZE = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    stack_alu_ext_if.slave                    bus,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(STACK_SIZE+1)-1:0]   depth
);
    localparam int unsigned DW = $clog2(STACK_SIZE + 1);
    localparam int unsigned AW = $clog2(STACK_SIZE);
    localparam int unsigned CW = $clog2(N);
    localparam int unsigned PW = 2 * N;

    localparam logic [3:0] OP_PUSH  = 4'b0001;
    localparam logic [3:0] OP_POP   = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_MUL   = 4'b0101;
    localparam logic [3:0] OP_DUP   = 4'b0110;
    localparam logic [3:0] OP_SWAP  = 4'b0111;
    localparam logic [3:0] OP_CLEAR = 4'b1000;

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   mem [STACK_SIZE];
    logic [DW-1:0]  depth_q, depth_d;
    logic [N-1:0]   out_q, out_d;
    logic           vld_q, vld_d, ovf_q, ovf_d, err_q, err_d;
    logic [PW-1:0]  mcand_q, mcand_d, acc_q, acc_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic           neg_q, neg_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           wr0_en, wr1_en;
    logic [AW-1:0]  wr0_idx, wr1_idx;
    logic [N-1:0]   wr0_data, wr1_data;

    logic [AW-1:0]  tos_idx, nos_idx, push_idx;
    logic [N-1:0]   tos, nos, tos_mag, nos_mag, sum, diff;
    logic           has1, has2, is_full, add_ovf, sub_ovf;
    logic           accept, mul_start, mul_last, mul_ovf;
    logic [PW-1:0]  acc_step, product;
    logic [N:0]     prod_hi;

    assign push_idx  = AW'(depth_q);
    assign tos_idx   = AW'(depth_q - DW'(1));
    assign nos_idx   = AW'(depth_q - DW'(2));
    assign tos       = mem[tos_idx];
    assign nos       = mem[nos_idx];
    assign has1      = depth_q != '0;
    assign has2      = depth_q >= DW'(2);
    assign is_full   = depth_q == DW'(STACK_SIZE);
    assign sum       = nos + tos;
    assign diff      = nos - tos;
    // Overflow when the result sign disagrees with NOS under the sign condition of each op.
    assign add_ovf   = (nos[N-1] == tos[N-1]) && (sum[N-1] != nos[N-1]);
    assign sub_ovf   = (nos[N-1] != tos[N-1]) && (diff[N-1] != nos[N-1]);
    assign tos_mag   = tos[N-1] ? -tos : tos;
    assign nos_mag   = nos[N-1] ? -nos : nos;

    assign accept    = bus.in_valid && (state_q == S_IDLE);
    assign mul_start = accept && (bus.opcode == OP_MUL) && has2;
    assign mul_last  = (state_q == S_MULT) && (cnt_q == CW'(N - 1));

    // Shift-add iteration on magnitudes; sign restored on the final product.
    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign product   = neg_q ? -acc_step : acc_step;
    assign prod_hi   = product[PW-1:N-1];
    assign mul_ovf   = (prod_hi != '0) && (prod_hi != '1);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (mul_start) state_d = S_MULT;
            S_MULT:  if (mul_last)  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM / registered outputs
    always_comb begin
        bus.in_ready    = (state_q == S_IDLE);
        bus.out_valid   = vld_q;
        bus.output_data = out_q;
        bus.overflow    = ovf_q;
        bus.stack_err   = err_q;
        depth           = depth_q;
        full            = depth_q == DW'(STACK_SIZE);
        empty           = depth_q == '0;
    end

    // Command decode and multiplier datapath
    always_comb begin
        depth_d  = depth_q;
        out_d    = out_q;
        vld_d    = 1'b0;
        ovf_d    = 1'b0;
        err_d    = 1'b0;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        wr0_en   = 1'b0;
        wr0_idx  = push_idx;
        wr0_data = bus.input_data;
        wr1_en   = 1'b0;
        wr1_idx  = nos_idx;
        wr1_data = tos;
        if (accept) begin
            vld_d = 1'b1;
            out_d = '0;
            case (bus.opcode)
                OP_PUSH: if (is_full) err_d = 1'b1;
                         else begin
                             wr0_en  = 1'b1;
                             depth_d = depth_q + DW'(1);
                             out_d   = bus.input_data;
                         end
                OP_POP:  if (!has1) err_d = 1'b1;
                         else begin
                             out_d   = tos;
                             depth_d = depth_q - DW'(1);
                         end
                OP_ADD, OP_SUB:
                         if (!has2) err_d = 1'b1;
                         else begin
                             wr0_en   = 1'b1;
                             wr0_idx  = nos_idx;
                             wr0_data = (bus.opcode == OP_ADD) ? sum : diff;
                             out_d    = wr0_data;
                             ovf_d    = (bus.opcode == OP_ADD) ? add_ovf : sub_ovf;
                             depth_d  = depth_q - DW'(1);
                         end
                OP_MUL:  if (!has2) err_d = 1'b1;
                         else begin
                             vld_d    = 1'b0;
                             out_d    = out_q;
                             neg_d    = nos[N-1] ^ tos[N-1];
                             mcand_d  = PW'(nos_mag);
                             mplier_d = tos_mag;
                             acc_d    = '0;
                             cnt_d    = '0;
                         end
                OP_DUP:  if (!has1 || is_full) err_d = 1'b1;
                         else begin
                             wr0_en   = 1'b1;
                             wr0_data = tos;
                             out_d    = tos;
                             depth_d  = depth_q + DW'(1);
                         end
                OP_SWAP: if (!has2) err_d = 1'b1;
                         else begin
                             wr0_en   = 1'b1;
                             wr0_idx  = tos_idx;
                             wr0_data = nos;
                             wr1_en   = 1'b1;
                             out_d    = nos;
                         end
                OP_CLEAR: depth_d = '0;
                default: ;
            endcase
        end else if (state_q == S_MULT) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (mul_last) begin
                vld_d    = 1'b1;
                out_d    = product[N-1:0];
                ovf_d    = mul_ovf;
                wr0_en   = 1'b1;
                wr0_idx  = nos_idx;
                wr0_data = product[N-1:0];
                depth_d  = depth_q - DW'(1);
            end
        end
    end

    // Control and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth_q  <= '0;
            out_q    <= '0;
            vld_q    <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            depth_q  <= depth_d;
            out_q    <= out_d;
            vld_q    <= vld_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
        end
    end

    // Stack storage keeps its contents across reset and CLEAR
    always_ff @(posedge clk) begin
        if (wr0_en) mem[wr0_idx] <= wr0_data;
        if (wr1_en) mem[wr1_idx] <= wr1_data;
    end
endmodule
